// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - grant encodings and access-alignment helper for the memory port arbiter
package mem_arb_pkg;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  // Byte accesses never misalign; half needs addr[0]=0; word needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic byte_acc, input logic half_acc,
                                         input logic [1:0] addr_lo);
    return !byte_acc && (half_acc ? addr_lo[0] : (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating count of consecutive fetch losses to the data port
module mem_arb_starve_ctr #(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !sat_o)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one unified memory between instruction fetch and the data port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic              d_half,
  input  logic              d_zext,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_stall,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte,
  output logic              mem_half,
  output logic              mem_zext,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]  gnt_sel;
  logic        starve_sat;
  logic        d_mis;
  logic        if_rvalid_q, d_rvalid_q, d_err_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  assign d_mis = is_misaligned(d_byte, d_half, d_addr[1:0]);

  // Data normally wins a conflict; fetch wins once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    gnt_sel = GNT_NONE;
    if (!rst) begin
      if (if_req && d_req)
        gnt_sel = starve_sat ? GNT_IF : GNT_D;
      else if (d_req)
        gnt_sel = GNT_D;
      else if (if_req)
        gnt_sel = GNT_IF;
    end
  end

  assign if_gnt   = (gnt_sel == GNT_IF);
  assign d_gnt    = (gnt_sel == GNT_D);
  assign if_stall = if_req & ~if_gnt;
  assign d_stall  = d_req & ~d_gnt;

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (if_req & d_req & d_gnt),
    .clr_i (if_gnt | ~if_req),
    .sat_o (starve_sat)
  );

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_byte  = 1'b0;
    mem_half  = 1'b0;
    mem_zext  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt_sel)
      GNT_IF: mem_addr = if_addr;
      GNT_D: begin
        mem_read  = ~d_we & ~d_mis;
        mem_write = d_we & ~d_mis;
        mem_byte  = d_byte;
        mem_half  = d_half;
        mem_zext  = d_zext;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // Read data is captured at the end of the grant cycle; stores and misaligned accesses return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      if_rvalid_q <= if_gnt;
      d_rvalid_q  <= d_gnt;
      if (if_gnt)
        if_rdata_q <= mem_rdata;
      if (d_gnt) begin
        d_rdata_q <= (d_we || d_mis) ? 32'd0 : mem_rdata;
        d_err_q   <= d_mis;
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter with a byte memory model
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_gnt, if_stall, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_byte, d_half, d_zext;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_stall, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_read, mem_write, mem_byte, mem_half, mem_zext;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [7:0]  mem [4096];
  int          checks_total;
  int          checks_passed;

  mem_port_arbiter #(.ADDR_W(12), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_half(d_half), .d_zext(d_zext),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_stall(d_stall),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte), .mem_half(mem_half),
    .mem_zext(mem_zext), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational little-endian read, write on posedge.
  logic [31:0] rd_word;
  always_comb begin
    rd_word = {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2], mem[mem_addr + 12'd1], mem[mem_addr]};
    mem_rdata = rd_word;
    if (mem_read && mem_byte)
      mem_rdata = mem_zext ? {24'd0, rd_word[7:0]} : {{24{rd_word[7]}}, rd_word[7:0]};
    else if (mem_read && mem_half)
      mem_rdata = mem_zext ? {16'd0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (!mem_byte) mem[mem_addr + 12'd1] <= mem_wdata[15:8];
      if (!mem_byte && !mem_half) begin
        mem[mem_addr + 12'd2] <= mem_wdata[23:16];
        mem[mem_addr + 12'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic req, input logic we, input logic bt, input logic hf,
                       input logic zx, input logic [11:0] a, input logic [31:0] wd);
    d_req = req; d_we = we; d_byte = bt; d_half = hf; d_zext = zx; d_addr = a; d_wdata = wd;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b0;
    #1;
    checks_total++; if (if_rvalid !== 1'b0) $display("FAIL rst_if_rvalid: got %b want 0", if_rvalid); else checks_passed++;
    checks_total++; if (d_rvalid !== 1'b0) $display("FAIL rst_d_rvalid: got %b want 0", d_rvalid); else checks_passed++;
    checks_total++; if (if_rdata !== 32'd0) $display("FAIL rst_if_rdata: got %h want 0", if_rdata); else checks_passed++;
    checks_total++; if (d_rdata !== 32'd0) $display("FAIL rst_d_rdata: got %h want 0", d_rdata); else checks_passed++;
    checks_total++; if (d_err !== 1'b0) $display("FAIL rst_d_err: got %b want 0", d_err); else checks_passed++;
    checks_total++; if ({if_gnt, d_gnt, mem_read, mem_write} !== 4'b0000) $display("FAIL rst_idle_ctl: got %b want 0000", {if_gnt, d_gnt, mem_read, mem_write}); else checks_passed++;
  endtask

  task automatic test_if_fetch();
    if_req = 1'b1; if_addr = 12'h000;
    #1;
    checks_total++; if (if_gnt !== 1'b1) $display("FAIL if_gnt: got %b want 1", if_gnt); else checks_passed++;
    checks_total++; if (mem_read !== 1'b0) $display("FAIL if_mem_read: got %b want 0", mem_read); else checks_passed++;
    checks_total++; if (if_stall !== 1'b0) $display("FAIL if_stall: got %b want 0", if_stall); else checks_passed++;
    tick();
    if_req = 1'b0;
    #1;
    checks_total++; if (if_rvalid !== 1'b1) $display("FAIL if_rvalid: got %b want 1", if_rvalid); else checks_passed++;
    checks_total++; if (if_rdata !== 32'h00500093) $display("FAIL if_rdata: got %h want 00500093", if_rdata); else checks_passed++;
    tick();
    checks_total++; if (if_rvalid !== 1'b0) $display("FAIL if_rvalid_pulse: got %b want 0", if_rvalid); else checks_passed++;
    checks_total++; if (if_rdata !== 32'h00500093) $display("FAIL if_rdata_hold: got %h want 00500093", if_rdata); else checks_passed++;
  endtask

  task automatic test_load_conflict();
    if_req = 1'b1; if_addr = 12'd4;
    set_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd1000, 32'd0);
    #1;
    checks_total++; if ({d_gnt, if_gnt, if_stall} !== 3'b101) $display("FAIL ld_arb: got %b want 101", {d_gnt, if_gnt, if_stall}); else checks_passed++;
    checks_total++; if ({mem_read, mem_write, mem_addr} !== {2'b10, 12'd1000}) $display("FAIL ld_mem_ctl: got %b %b %0d want 1 0 1000", mem_read, mem_write, mem_addr); else checks_passed++;
    tick();
    d_req = 1'b0;
    #1;
    checks_total++; if ({d_rvalid, d_err} !== 2'b10) $display("FAIL ld_rvalid: got %b want 10", {d_rvalid, d_err}); else checks_passed++;
    checks_total++; if (d_rdata !== 32'd17) $display("FAIL ld_rdata: got %0d want 17", d_rdata); else checks_passed++;
    checks_total++; if ({if_gnt, mem_addr} !== {1'b1, 12'd4}) $display("FAIL ld_if_next: got %b %0d want 1 4", if_gnt, mem_addr); else checks_passed++;
    tick();
    if_req = 1'b0;
    #1;
    checks_total++; if (if_rdata !== 32'h00100113) $display("FAIL ld_if_rdata: got %h want 00100113", if_rdata); else checks_passed++;
    checks_total++; if (d_rvalid !== 1'b0) $display("FAIL ld_rvalid_pulse: got %b want 0", d_rvalid); else checks_passed++;
  endtask

  task automatic test_starvation();
    logic [1:0] exp_gnt [4];
    logic       exp_stall [4];
    exp_gnt = '{2'b10, 2'b10, 2'b01, 2'b10};
    exp_stall = '{1'b1, 1'b1, 1'b0, 1'b0};
    if_req = 1'b1; if_addr = 12'd0;
    set_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd1000, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks_total++; if ({d_gnt, if_gnt} !== exp_gnt[i]) $display("FAIL starve_gnt%0d: got %b want %b", i, {d_gnt, if_gnt}, exp_gnt[i]); else checks_passed++;
      checks_total++; if (if_stall !== exp_stall[i]) $display("FAIL starve_stall%0d: got %b want %b", i, if_stall, exp_stall[i]); else checks_passed++;
      tick();
      if (exp_gnt[i] == 2'b01) if_req = 1'b0;
    end
    d_req = 1'b0;
    #1;
    checks_total++; if ({d_rvalid, d_rdata} !== {1'b1, 32'd17}) $display("FAIL starve_last_ld: got %b %0d want 1 17", d_rvalid, d_rdata); else checks_passed++;
    tick();
  endtask

  task automatic test_store_half();
    set_d(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd1004, 32'h1234BEEF);
    #1;
    checks_total++; if ({mem_write, mem_read, mem_half, mem_byte} !== 4'b1010) $display("FAIL sh_ctl: got %b want 1010", {mem_write, mem_read, mem_half, mem_byte}); else checks_passed++;
    tick();
    checks_total++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'd0}) $display("FAIL sh_ack: got %b %b %h want 1 0 0", d_rvalid, d_err, d_rdata); else checks_passed++;
    checks_total++; if ({mem[1005], mem[1004]} !== 16'hBEEF) $display("FAIL sh_mem: got %h want BEEF", {mem[1005], mem[1004]}); else checks_passed++;
    checks_total++; if (mem[1006] !== 8'h00) $display("FAIL sh_mem_hi: got %h want 00", mem[1006]); else checks_passed++;
    set_d(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'd1004, 32'd0);
    #1;
    checks_total++; if ({mem_read, mem_write, mem_zext} !== 3'b101) $display("FAIL lhu_ctl: got %b want 101", {mem_read, mem_write, mem_zext}); else checks_passed++;
    tick();
    checks_total++; if (d_rdata !== 32'h0000BEEF) $display("FAIL lhu_rdata: got %h want 0000BEEF", d_rdata); else checks_passed++;
    set_d(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1004, 32'd0);
    tick();
    checks_total++; if (d_rdata !== 32'hFFFFBEEF) $display("FAIL lh_rdata: got %h want FFFFBEEF", d_rdata); else checks_passed++;
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    set_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd1002, 32'd0);
    #1;
    checks_total++; if ({d_gnt, mem_read, mem_write} !== 3'b100) $display("FAIL mis_lw_ctl: got %b want 100", {d_gnt, mem_read, mem_write}); else checks_passed++;
    tick();
    checks_total++; if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'd0}) $display("FAIL mis_lw_resp: got %b %b %h want 1 1 0", d_rvalid, d_err, d_rdata); else checks_passed++;
    set_d(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd1005, 32'h00001111);
    #1;
    checks_total++; if ({d_gnt, mem_write} !== 2'b10) $display("FAIL mis_sh_ctl: got %b want 10", {d_gnt, mem_write}); else checks_passed++;
    tick();
    checks_total++; if (mem[1005] !== 8'hBE) $display("FAIL mis_sh_mem: got %h want BE", mem[1005]); else checks_passed++;
    checks_total++; if (d_err !== 1'b1) $display("FAIL mis_sh_err: got %b want 1", d_err); else checks_passed++;
    set_d(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'd1005, 32'd0);
    tick();
    checks_total++; if ({d_err, d_rdata} !== {1'b0, 32'h000000BE}) $display("FAIL lbu_odd: got %b %h want 0 000000BE", d_err, d_rdata); else checks_passed++;
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 12'd8;
    set_d(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd1008, 32'h0000DEAD);
    rst = 1'b1;
    #1;
    checks_total++; if ({mem_write, d_gnt, if_gnt, mem_read} !== 4'b0000) $display("FAIL rstmid_ctl: got %b want 0000", {mem_write, d_gnt, if_gnt, mem_read}); else checks_passed++;
    tick();
    rst = 1'b0;
    if_req = 1'b0; d_req = 1'b0;
    #1;
    checks_total++; if ({if_rvalid, d_rvalid} !== 2'b00) $display("FAIL rstmid_rvalid: got %b want 00", {if_rvalid, d_rvalid}); else checks_passed++;
    checks_total++; if ({mem[1009], mem[1008]} !== 16'h0200) $display("FAIL rstmid_mem: got %h want 0200", {mem[1009], mem[1008]}); else checks_passed++;
    set_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd1008, 32'd0);
    tick();
    d_req = 1'b0;
    checks_total++; if ({d_rvalid, d_rdata} !== {1'b1, 32'd512}) $display("FAIL rstmid_lw: got %b %0d want 1 512", d_rvalid, d_rdata); else checks_passed++;
    tick();
  endtask

  initial begin
    checks_total = 0;
    checks_passed = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    {mem[3], mem[2], mem[1], mem[0]} = 32'h00500093;
    {mem[7], mem[6], mem[5], mem[4]} = 32'h00100113;
    {mem[1003], mem[1002], mem[1001], mem[1000]} = 32'd17;
    {mem[1011], mem[1010], mem[1009], mem[1008]} = 32'd512;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    set_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
    repeat (2) @(posedge clk);
    test_reset();
    test_if_fetch();
    test_load_conflict();
    test_starvation();
    test_store_half();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
